spi_cmd_sequencer: RTL and testbench



---
 rtl/spi_cmd_sequencer_pkg.sv | 35 +++
 rtl/spi_cmd_sequencer_byte_pack.sv | 28 ++
 rtl/spi_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared definitions for the SPI command sequencer: command-word layout,
// FSM states and the status-word builder.
package spi_cmd_sequencer_pkg;

    localparam int GO_BIT         = 31;
    localparam int DONE_BIT       = 30;
    localparam int ERR_BIT        = 29;
    localparam int OPC_LSB        = 16;
    localparam int NW_LSB         = 8;
    localparam int NR_LSB         = 0;
    localparam int FIELD_W        = 8;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [7:0] DUMMY_BYTE = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POLL,
        ST_CHECK,
        ST_SETUP,
        ST_OP,
        ST_TX_FETCH,
        ST_TX_BYTE,
        ST_RX_BYTE,
        ST_RX_STORE,
        ST_HOLD,
        ST_STATUS
    } state_t;

    // Completion word: GO cleared, DONE set, low 29 bits of the command kept.
    function automatic logic [31:0] status_word(input logic err, input logic [28:0] cmd_lo);
        return {1'b0, 1'b1, err, cmd_lo};
    endfunction

endpackage

// File: rtl/spi_cmd_sequencer_byte_pack.sv
// Big-endian byte lane helper: selects one byte out of a word, and merges
// one byte into a word at a given lane (byte 0 sits in bits [31:24]).
module spi_byte_pack
    import spi_cmd_sequencer_pkg::*;
(
    input  logic [31:0] sel_word,
    input  logic [1:0]  sel_idx,
    output logic [7:0]  sel_byte,
    input  logic [31:0] asm_word,
    input  logic [7:0]  asm_byte,
    input  logic [1:0]  asm_idx,
    output logic [31:0] asm_next
);

    logic [7:0] lanes [BYTES_PER_WORD];

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign lanes[gi] = sel_word[31 - 8*gi -: 8];
            assign asm_next[31 - 8*gi -: 8] = (asm_idx == 2'(gi)) ? asm_byte
                                                                  : asm_word[31 - 8*gi -: 8];
        end
    endgenerate

    assign sel_byte = lanes[sel_idx];

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Polls a command word in the shared buffer, runs one SPI flash transaction
// (opcode, N write bytes, M read bytes) and writes back a status word.
module spi_cmd_sequencer
    import spi_cmd_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int CMD_ADDR  = 0,
    parameter int TX_BASE   = 1,
    parameter int RX_BASE   = 16,
    parameter int MAX_BYTES = 60,
    parameter int POLL_GAP  = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic              buf_req,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [31:0]       buf_dout,
    input  logic [31:0]       buf_din,
    input  logic              buf_ack,
    output logic              sh_start,
    output logic [7:0]        sh_tx,
    input  logic [7:0]        sh_rx,
    input  logic              sh_done,
    output logic              cs_n,
    output logic              busy,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] CMD_A    = ADDR_W'(CMD_ADDR);
    localparam logic [ADDR_W-1:0] TX_A     = ADDR_W'(TX_BASE);
    localparam logic [ADDR_W-1:0] RX_A     = ADDR_W'(RX_BASE);
    localparam logic [7:0]        MAX_B    = 8'(MAX_BYTES);
    localparam logic [15:0]       GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    state_t      state_reg;
    logic [15:0] poll_cnt_reg;
    logic [28:0] cmd_reg;
    logic        err_reg;
    logic [7:0]  k_reg;
    logic [7:0]  j_reg;
    logic [31:0] tx_hold_reg;
    logic [31:0] rx_asm_reg;
    logic        sh_issued_reg;

    logic [7:0]  opc;
    logic [7:0]  nw;
    logic [7:0]  nr;
    logic [7:0]  k_next;
    logic [7:0]  j_next;
    logic [7:0]  tx_byte;
    logic [31:0] rx_asm_next;

    assign opc    = cmd_reg[OPC_LSB +: FIELD_W];
    assign nw     = cmd_reg[NW_LSB  +: FIELD_W];
    assign nr     = cmd_reg[NR_LSB  +: FIELD_W];
    assign k_next = k_reg + 8'd1;
    assign j_next = j_reg + 8'd1;
    assign busy   = (state_reg != ST_IDLE) && (state_reg != ST_POLL);

    spi_byte_pack u_pack (
        .sel_word (tx_hold_reg),
        .sel_idx  (k_reg[1:0]),
        .sel_byte (tx_byte),
        .asm_word (rx_asm_reg),
        .asm_byte (sh_rx),
        .asm_idx  (j_reg[1:0]),
        .asm_next (rx_asm_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            poll_cnt_reg  <= '0;
            cmd_reg       <= '0;
            err_reg       <= 1'b0;
            k_reg         <= '0;
            j_reg         <= '0;
            tx_hold_reg   <= '0;
            rx_asm_reg    <= '0;
            sh_issued_reg <= 1'b0;
            buf_req       <= 1'b0;
            buf_we        <= 1'b0;
            buf_addr      <= '0;
            buf_dout      <= '0;
            sh_start      <= 1'b0;
            sh_tx         <= '0;
            cs_n          <= 1'b1;
            irq           <= 1'b0;
        end else begin
            sh_start <= 1'b0;
            irq      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (poll_cnt_reg == GAP_LAST) begin
                        poll_cnt_reg <= '0;
                        state_reg    <= ST_POLL;
                        buf_req      <= 1'b1;
                        buf_we       <= 1'b0;
                        buf_addr     <= CMD_A;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + 16'd1;
                    end
                end
                ST_POLL: begin
                    if (buf_ack) begin
                        buf_req <= 1'b0;
                        if (buf_din[GO_BIT]) begin
                            cmd_reg   <= buf_din[28:0];
                            state_reg <= ST_CHECK;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                ST_CHECK: begin
                    k_reg         <= '0;
                    j_reg         <= '0;
                    rx_asm_reg    <= '0;
                    sh_issued_reg <= 1'b0;
                    // Out-of-range counts are rejected before the bus is touched.
                    if (nw > MAX_B || nr > MAX_B) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_STATUS;
                        buf_req   <= 1'b1;
                        buf_we    <= 1'b1;
                        buf_addr  <= CMD_A;
                        buf_dout  <= status_word(1'b1, cmd_reg);
                    end else begin
                        err_reg   <= 1'b0;
                        cs_n      <= 1'b0;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: state_reg <= ST_OP;
                ST_OP: begin
                    if (!sh_issued_reg) begin
                        sh_start      <= 1'b1;
                        sh_tx         <= opc;
                        sh_issued_reg <= 1'b1;
                    end else if (sh_done) begin
                        sh_issued_reg <= 1'b0;
                        if (nw != 8'd0) begin
                            state_reg <= ST_TX_FETCH;
                            buf_req   <= 1'b1;
                            buf_we    <= 1'b0;
                            buf_addr  <= TX_A;
                        end else if (nr != 8'd0) begin
                            state_reg <= ST_RX_BYTE;
                        end else begin
                            cs_n      <= 1'b1;
                            state_reg <= ST_HOLD;
                        end
                    end
                end
                ST_TX_FETCH: begin
                    if (buf_ack) begin
                        buf_req     <= 1'b0;
                        tx_hold_reg <= buf_din;
                        state_reg   <= ST_TX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    if (!sh_issued_reg) begin
                        sh_start      <= 1'b1;
                        sh_tx         <= tx_byte;
                        sh_issued_reg <= 1'b1;
                    end else if (sh_done) begin
                        sh_issued_reg <= 1'b0;
                        k_reg         <= k_next;
                        if (k_next == nw) begin
                            if (nr != 8'd0) begin
                                state_reg <= ST_RX_BYTE;
                            end else begin
                                cs_n      <= 1'b1;
                                state_reg <= ST_HOLD;
                            end
                        end else if (k_next[1:0] == 2'd0) begin
                            state_reg <= ST_TX_FETCH;
                            buf_req   <= 1'b1;
                            buf_we    <= 1'b0;
                            buf_addr  <= TX_A + ADDR_W'(k_next >> 2);
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (!sh_issued_reg) begin
                        sh_start      <= 1'b1;
                        sh_tx         <= DUMMY_BYTE;
                        sh_issued_reg <= 1'b1;
                    end else if (sh_done) begin
                        sh_issued_reg <= 1'b0;
                        j_reg         <= j_next;
                        rx_asm_reg    <= rx_asm_next;
                        if (j_next[1:0] == 2'd0 || j_next == nr) begin
                            state_reg <= ST_RX_STORE;
                            buf_req   <= 1'b1;
                            buf_we    <= 1'b1;
                            buf_addr  <= RX_A + ADDR_W'((j_next - 8'd1) >> 2);
                            buf_dout  <= rx_asm_next;
                        end
                    end
                end
                ST_RX_STORE: begin
                    if (buf_ack) begin
                        buf_req    <= 1'b0;
                        rx_asm_reg <= '0;
                        if (j_reg < nr) begin
                            state_reg <= ST_RX_BYTE;
                        end else begin
                            cs_n      <= 1'b1;
                            state_reg <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    state_reg <= ST_STATUS;
                    buf_req   <= 1'b1;
                    buf_we    <= 1'b1;
                    buf_addr  <= CMD_A;
                    buf_dout  <= status_word(err_reg, cmd_reg);
                end
                ST_STATUS: begin
                    if (buf_ack) begin
                        buf_req   <= 1'b0;
                        irq       <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench: behavioural buffer and shifter models, expected bytes and
// buffer writes queued by the stimulus, compared by an independent monitor.
module tb_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buf_req, buf_we;
    logic [7:0]  buf_addr;
    logic [31:0] buf_dout;
    logic [31:0] buf_din = '0;
    logic        buf_ack = 1'b0;
    logic        sh_start;
    logic [7:0]  sh_tx;
    logic [7:0]  sh_rx = '0;
    logic        sh_done = 1'b0;
    logic        cs_n, busy, irq;

    spi_cmd_sequencer #(
        .ADDR_W(8), .CMD_ADDR(0), .TX_BASE(1), .RX_BASE(16), .MAX_BYTES(60), .POLL_GAP(15)
    ) dut (
        .clk(clk), .rst(rst),
        .buf_req(buf_req), .buf_we(buf_we), .buf_addr(buf_addr), .buf_dout(buf_dout),
        .buf_din(buf_din), .buf_ack(buf_ack),
        .sh_start(sh_start), .sh_tx(sh_tx), .sh_rx(sh_rx), .sh_done(sh_done),
        .cs_n(cs_n), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [256];
    logic [7:0]  exp_tx [$];
    logic [7:0]  rx_src [$];
    wr_t         exp_wr [$];
    int          start_cnt = 0, irq_cnt = 0, tx_reads = 0, rx_writes = 0;
    bit          cs_low_seen = 0;
    bit          rand_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Buffer model: one ack per request after 0..7 cycles of latency.
    bit          armed = 0;
    int          ack_wait = 0;
    logic        ack_we;
    logic [7:0]  ack_addr;
    logic [31:0] ack_data;
    always @(negedge clk) begin
        if (rst) begin
            buf_ack = 1'b0;
            armed   = 0;
        end else if (buf_ack) begin
            buf_ack = 1'b0;
        end else if (buf_req) begin
            if (!armed) begin
                armed    = 1;
                ack_wait = rand_delay ? int'($urandom_range(0, 7)) : 0;
            end
            if (ack_wait == 0) begin
                armed    = 0;
                buf_ack  = 1'b1;
                ack_we   = buf_we;
                ack_addr = buf_addr;
                ack_data = buf_dout;
                if (buf_we) mem[buf_addr] = buf_dout;
                else        buf_din = mem[buf_addr];
            end else begin
                ack_wait--;
            end
        end
    end

    // Shifter model: done three cycles after start, returns the next queued byte.
    bit sh_busy = 0;
    int sh_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            sh_done = 1'b0;
            sh_busy = 0;
        end else if (sh_done) begin
            sh_done = 1'b0;
        end else if (sh_busy) begin
            if (sh_cnt == 0) begin
                sh_busy = 0;
                sh_done = 1'b1;
                sh_rx   = (rx_src.size() > 0) ? rx_src.pop_front() : 8'h00;
            end else begin
                sh_cnt--;
            end
        end else if (sh_start) begin
            sh_busy = 1;
            sh_cnt  = 2;
        end
    end

    // Monitor: compares every shifted byte and buffer write against the queues.
    logic        prev_req = 1'b0, prev_we;
    logic [7:0]  prev_addr;
    logic [31:0] prev_dout;
    logic [7:0]  e_tx;
    wr_t         e_wr;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (prev_req && !buf_ack)
                check("buf_req_stable",
                      {31'd0, (buf_req && buf_we == prev_we && buf_addr == prev_addr
                               && buf_dout == prev_dout)}, 32'd1);
            if (!cs_n) cs_low_seen = 1;
            if (irq) irq_cnt++;
            if (sh_start) begin
                start_cnt++;
                check("cs_n_at_start", {31'd0, cs_n}, 32'd0);
                if (exp_tx.size() == 0) begin
                    check("unexpected_start_tx", {24'd0, sh_tx}, 32'hFFFF_FFFF);
                end else begin
                    e_tx = exp_tx.pop_front();
                    check("sh_tx", {24'd0, sh_tx}, {24'd0, e_tx});
                end
            end
            if (buf_ack) begin
                if (ack_we) begin
                    if (ack_addr >= 8'd16) rx_writes++;
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write_addr", {24'd0, ack_addr}, 32'hFFFF_FFFF);
                    end else begin
                        e_wr = exp_wr.pop_front();
                        check("buf_wr_addr", {24'd0, ack_addr}, {24'd0, e_wr.addr});
                        check("buf_wr_data", ack_data, e_wr.data);
                    end
                end else if (ack_addr >= 8'd1 && ack_addr <= 8'd15) begin
                    tx_reads++;
                end
            end
            prev_req  = buf_req;
            prev_we   = buf_we;
            prev_addr = buf_addr;
            prev_dout = buf_dout;
        end
    end

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic wait_irq(input string name);
        int base = irq_cnt;
        int n = 0;
        while (irq_cnt == base && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_completed"}, {31'd0, (irq_cnt != base)}, 32'd1);
        repeat (20) @(posedge clk);
        #2;
        check({name, "_irq_pulses"}, irq_cnt - base, 32'd1);
        check({name, "_tx_left"}, exp_tx.size(), 32'd0);
        check({name, "_wr_left"}, exp_wr.size(), 32'd0);
        check({name, "_cs_n_idle"}, {31'd0, cs_n}, 32'd1);
        check({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic setup_read_id();
        exp_tx.push_back(8'h9F);
        repeat (3) exp_tx.push_back(8'h00);
        rx_src.push_back(8'hFF);
        rx_src.push_back(8'hEF);
        rx_src.push_back(8'h40);
        rx_src.push_back(8'h18);
        push_wr(8'd16, 32'hEF40_1800);
        push_wr(8'd0,  32'h409F_0003);
    endtask

    task automatic setup_read5();
        exp_tx.push_back(8'h03);
        repeat (5) exp_tx.push_back(8'h00);
        rx_src.push_back(8'hFF);
        rx_src.push_back(8'h11);
        rx_src.push_back(8'h22);
        rx_src.push_back(8'h33);
        rx_src.push_back(8'h44);
        rx_src.push_back(8'h55);
        push_wr(8'd16, 32'h1122_3344);
        push_wr(8'd17, 32'h5500_0000);
        push_wr(8'd0,  32'h4003_0005);
    endtask

    int s0, r0, w0, n;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_buf_req",  {31'd0, buf_req},  32'd0);
        check("rst_buf_we",   {31'd0, buf_we},   32'd0);
        check("rst_buf_addr", {24'd0, buf_addr}, 32'd0);
        check("rst_buf_dout", buf_dout,          32'd0);
        check("rst_sh_start", {31'd0, sh_start}, 32'd0);
        check("rst_sh_tx",    {24'd0, sh_tx},    32'd0);
        check("rst_cs_n",     {31'd0, cs_n},     32'd1);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_irq",      {31'd0, irq},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Read ID: opcode 9F, three read bytes.
        s0 = start_cnt;
        setup_read_id();
        mem[0] = 32'h809F_0003;
        wait_irq("read_id");
        check("read_id_starts", start_cnt - s0, 32'd4);
        $display("txn read_id cmd=809f0003 starts=%0d status=%h", start_cnt - s0, mem[0]);

        // Page write: six write bytes spanning two TX words.
        s0 = start_cnt; r0 = tx_reads; w0 = rx_writes;
        exp_tx.push_back(8'h02);
        exp_tx.push_back(8'h0A); exp_tx.push_back(8'h0B); exp_tx.push_back(8'h0C);
        exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0E); exp_tx.push_back(8'h0F);
        push_wr(8'd0, 32'h4002_0600);
        mem[1] = 32'h0A0B_0C0D;
        mem[2] = 32'h0E0F_1234;
        mem[0] = 32'h8002_0600;
        wait_irq("page_write");
        check("page_write_starts",   start_cnt - s0, 32'd7);
        check("page_write_fetches",  tx_reads - r0,  32'd2);
        check("page_write_rx_wr",    rx_writes - w0, 32'd0);
        $display("txn page_write cmd=80020600 starts=%0d fetches=%0d", start_cnt - s0, tx_reads - r0);

        // Bad count: N=61 is rejected without touching the SPI bus.
        s0 = start_cnt; cs_low_seen = 0;
        push_wr(8'd0, 32'h6000_3D00);
        mem[0] = 32'h8000_3D00;
        wait_irq("bad_count");
        check("bad_count_starts", start_cnt - s0, 32'd0);
        check("bad_count_cs_low", {31'd0, cs_low_seen}, 32'd0);
        $display("txn bad_count cmd=80003d00 status=%h", mem[0]);

        // Opcode only.
        s0 = start_cnt; cs_low_seen = 0;
        exp_tx.push_back(8'h06);
        push_wr(8'd0, 32'h4006_0000);
        mem[0] = 32'h8006_0000;
        wait_irq("opcode_only");
        check("opcode_only_starts", start_cnt - s0, 32'd1);
        check("opcode_only_cs_low", {31'd0, cs_low_seen}, 32'd1);
        $display("txn opcode_only cmd=80060000 starts=%0d", start_cnt - s0);

        // Five read bytes: partial second word is left-justified.
        s0 = start_cnt; w0 = rx_writes;
        setup_read5();
        mem[0] = 32'h8003_0005;
        wait_irq("read5");
        check("read5_starts",    start_cnt - s0, 32'd6);
        check("read5_rx_writes", rx_writes - w0, 32'd2);
        $display("txn read5 cmd=80030005 rx0=%h rx1=%h", mem[16], mem[17]);

        // Reset during the third byte shift, then the command reruns.
        s0 = start_cnt;
        setup_read_id();
        mem[0] = 32'h809F_0003;
        n = 0;
        while (start_cnt - s0 < 3 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_rst_reached_third", {31'd0, (start_cnt - s0 >= 3)}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_cs_n",     {31'd0, cs_n},     32'd1);
        check("mid_rst_buf_req",  {31'd0, buf_req},  32'd0);
        check("mid_rst_sh_start", {31'd0, sh_start}, 32'd0);
        check("mid_rst_busy",     {31'd0, busy},     32'd0);
        check("mid_rst_irq",      {31'd0, irq},      32'd0);
        check("mid_rst_buf_addr", {24'd0, buf_addr}, 32'd0);
        exp_tx.delete();
        exp_wr.delete();
        rx_src.delete();
        repeat (3) @(negedge clk);
        check("mid_rst_go_kept", mem[0], 32'h809F_0003);
        rst = 1'b0;
        s0 = start_cnt;
        setup_read_id();
        wait_irq("rerun_after_rst");
        check("rerun_starts", start_cnt - s0, 32'd4);
        $display("txn rerun_after_rst cmd=809f0003 starts=%0d status=%h", start_cnt - s0, mem[0]);

        // Random buffer latency: same results expected.
        rand_delay = 1;
        s0 = start_cnt;
        setup_read_id();
        mem[0] = 32'h809F_0003;
        wait_irq("read_id_slow");
        check("read_id_slow_starts", start_cnt - s0, 32'd4);
        $display("txn read_id_slow cmd=809f0003 starts=%0d", start_cnt - s0);

        s0 = start_cnt;
        setup_read5();
        mem[0] = 32'h8003_0005;
        wait_irq("read5_slow");
        check("read5_slow_starts", start_cnt - s0, 32'd6);
        $display("txn read5_slow cmd=80030005 starts=%0d", start_cnt - s0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
